// File: rtl/data_ram_if.sv
// Dual-port data memory bus: port A (pipeline MEM/WB) and port B (debug/host).
// Both ports use word addresses, byte-lane write enables and registered read data.
interface data_ram_if;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [3:0]  web;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;

    modport master (
        output wea, addra, dina, web, addrb, dinb,
        input  douta, doutb
    );

    modport slave (
        input  wea, addra, dina, web, addrb, dinb,
        output douta, doutb
    );
endinterface

// File: rtl/data_ram.sv
// True dual-port 32-bit data memory with per-byte write enables.
// Reads are READ_FIRST. When both ports write the same byte, port A wins.
module data_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic      clk,
    input  logic      rst,
    data_ram_if.slave bus
);
    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx_a;
    logic [ADDR_WIDTH-1:0] idx_b;

    // Only the low address bits decode, so the array aliases across the full 30-bit word space.
    assign idx_a = ADDR_WIDTH'(bus.addra % DEPTH_W);
    assign idx_b = ADDR_WIDTH'(bus.addrb % DEPTH_W);

    // Reset clears only the read registers and blocks writes. The array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.douta <= 32'h0;
            bus.doutb <= 32'h0;
        end else begin
            bus.douta <= mem[idx_a];
            bus.doutb <= mem[idx_b];
            // Port B lanes are written first, so port A's later assignment wins any shared lane.
            for (int i = 0; i < 4; i++) begin
                if (bus.web[i]) mem[idx_b][8*i +: 8] <= bus.dinb[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.wea[i]) mem[idx_a][8*i +: 8] <= bus.dina[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed vector table followed by randomized traffic
// compared against an array-based memory model.
module tb_data_ram;
    localparam int AW    = 12;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_ram_if bus ();

    data_ram #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] model [DEPTH];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  wea;
        logic [29:0] addra;
        logic [31:0] dina;
        logic [3:0]  web;
        logic [29:0] addrb;
        logic [31:0] dinb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // The model predicts outputs from the pre-edge contents, then applies the byte writes.
    // For a shared byte, port A's data replaces port B's.
    task automatic step(output logic [31:0] ea, output logic [31:0] eb);
        int ia;
        int ib;
        ia = int'(bus.addra) % DEPTH;
        ib = int'(bus.addrb) % DEPTH;
        if (rst) begin
            ea = 32'h0;
            eb = 32'h0;
        end else begin
            ea = model[ia];
            eb = model[ib];
            for (int i = 0; i < 4; i++) begin
                if (bus.web[i]) model[ib][8*i +: 8] = bus.dinb[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.wea[i]) model[ia][8*i +: 8] = bus.dina[8*i +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic [29:0] hi;

        bus.wea   = 4'h0;
        bus.addra = 30'h0;
        bus.dina  = 32'h0;
        bus.web   = 4'h0;
        bus.addrb = 30'h0;
        bus.dinb  = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // Zero every word through both ports so the model and the array agree.
        for (int i = 0; i < DEPTH / 2; i++) begin
            bus.wea   = 4'hF;
            bus.addra = 30'(2 * i);
            bus.dina  = 32'h0;
            bus.web   = 4'hF;
            bus.addrb = 30'(2 * i + 1);
            bus.dinb  = 32'h0;
            step(ea, eb);
        end

        vecs[0]  = '{1'b1, 4'h0, 30'd0,         32'h0,        4'h0, 30'd0,      32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 4'hF, 30'd5,         32'hDEADBEEF, 4'h0, 30'd0,      32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 4'h0, 30'd5,         32'h0,        4'h0, 30'd5,      32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'h4, 30'd5,         32'h00AA0000, 4'h0, 30'd5,      32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 4'h3, 30'd5,         32'h00001234, 4'h0, 30'd5,      32'h0,        32'hDEAABEEF, 32'hDEAABEEF};
        vecs[5]  = '{1'b0, 4'h0, 30'd5,         32'h0,        4'h0, 30'd5,      32'h0,        32'hDEAA1234, 32'hDEAA1234};
        vecs[6]  = '{1'b0, 4'hF, 30'd7,         32'h11111111, 4'h0, 30'd0,      32'h0,        32'h0,        32'h0};
        vecs[7]  = '{1'b0, 4'hF, 30'd7,         32'h22222222, 4'h0, 30'd7,      32'h0,        32'h11111111, 32'h11111111};
        vecs[8]  = '{1'b0, 4'h0, 30'd7,         32'h0,        4'h0, 30'd7,      32'h0,        32'h22222222, 32'h22222222};
        vecs[9]  = '{1'b0, 4'hF, 30'd9,         32'hAAAAAAAA, 4'h9, 30'd9,      32'hBBBBBBBB, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 4'h3, 30'd9,         32'hAAAAAAAA, 4'hC, 30'd9,      32'hBBBBBBBB, 32'hAAAAAAAA, 32'hAAAAAAAA};
        vecs[11] = '{1'b0, 4'h0, 30'd9,         32'h0,        4'h0, 30'd9,      32'h0,        32'hBBBBAAAA, 32'hBBBBAAAA};
        vecs[12] = '{1'b0, 4'hF, 30'd0,         32'h00000005, 4'h0, 30'd4096,   32'h0,        32'h0,        32'h0};
        vecs[13] = '{1'b0, 4'h0, 30'd0,         32'h0,        4'h0, 30'd4096,   32'h0,        32'h00000005, 32'h00000005};
        vecs[14] = '{1'b1, 4'hF, 30'd0,         32'h00000077, 4'hF, 30'd9,      32'h00000001, 32'h0,        32'h0};
        vecs[15] = '{1'b0, 4'h0, 30'd0,         32'h0,        4'h0, 30'd9,      32'h0,        32'h00000005, 32'hBBBBAAAA};
        vecs[16] = '{1'b0, 4'h0, 30'h3FFFF005,  32'h0,        4'h0, 30'h1007,   32'h0,        32'hDEAA1234, 32'h22222222};

        foreach (vecs[k]) begin
            rst       = vecs[k].rst;
            bus.wea   = vecs[k].wea;
            bus.addra = vecs[k].addra;
            bus.dina  = vecs[k].dina;
            bus.web   = vecs[k].web;
            bus.addrb = vecs[k].addrb;
            bus.dinb  = vecs[k].dinb;
            step(ea, eb);
            check($sformatf("vec%0d_douta", k), bus.douta, vecs[k].exp_a);
            check($sformatf("vec%0d_doutb", k), bus.doutb, vecs[k].exp_b);
        end

        // Random traffic over a few hot words with random upper bits, to hit collisions and aliasing.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 19) == 0);
            hi        = 30'($urandom) & ~30'(DEPTH - 1);
            bus.addra = hi | 30'($urandom_range(0, 7));
            hi        = 30'($urandom) & ~30'(DEPTH - 1);
            bus.addrb = hi | 30'($urandom_range(0, 7));
            bus.wea   = 4'($urandom);
            bus.web   = 4'($urandom);
            bus.dina  = $urandom;
            bus.dinb  = $urandom;
            step(ea, eb);
            check($sformatf("rand%0d_douta", n), bus.douta, ea);
            check($sformatf("rand%0d_doutb", n), bus.doutb, eb);
        end

        // Read back the hot words through both ports to check the final contents.
        rst     = 1'b0;
        bus.wea = 4'h0;
        bus.web = 4'h0;
        for (int w = 0; w < 8; w++) begin
            bus.addra = 30'(w);
            bus.addrb = 30'(w) | 30'(DEPTH);
            step(ea, eb);
            check($sformatf("final%0d_douta", w), bus.douta, ea);
            check($sformatf("final%0d_doutb", w), bus.doutb, eb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
